cpu_inta_initiator: RTL

CPU_INTA_INITIATOR -- requirements
Module: cpu_inta_initiator

---
 rtl/cpu_inta_initiator_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 21 ++
 rtl/cpu_inta_initiator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_inta_initiator_pkg.sv
// Shared types and constants for the CPU interrupt-acknowledge initiator.
package cpu_inta_initiator_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned CNT_W  = 4;

    localparam logic [DATA_W-1:0] CALL_OPCODE = 8'hCD;
    localparam logic [IDX_W-1:0]  PULSES_8086 = 2'd2;
    localparam logic [IDX_W-1:0]  PULSES_8080 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bytes gathered before the final pulse; the final byte goes straight to the outputs.
    typedef struct packed {
        logic [DATA_W-1:0] lo;
        logic              opBad;
    } capture_t;

    function automatic logic [IDX_W-1:0] lastPulseIdx(input logic is8086);
        return is8086 ? (PULSES_8086 - 2'd1) : (PULSES_8080 - 2'd1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cpu_inta_initiator.sv
// Issues 8086 (two-pulse) or 8080 (three-pulse) INTA_n sequences and captures the PIC response.
module cpu_inta_initiator
    import cpu_inta_initiator_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              INT,
    input  logic              int_enable,
    input  logic              mode_8086,
    input  logic [DATA_W-1:0] data_in,
    output logic              INTA_n,
    output logic [DATA_W-1:0] vector,
    output logic [ADDR_W-1:0] isr_addr,
    output logic              vector_valid,
    output logic              proto_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    logic intS;

    state_e            stateQ, stateNext;
    logic [IDX_W-1:0]  pulseIdx, pulseIdxNext;
    logic [CNT_W-1:0]  cycleCnt, cycleCntNext;
    logic              mode8086Q, mode8086Next;
    capture_t          capQ, capNext;

    logic              intaNext;
    logic              busyNext;
    logic              validNext;
    logic              errNext;
    logic [DATA_W-1:0] vectorNext;
    logic [ADDR_W-1:0] isrAddrNext;

    sync_2ff uSync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (INT),
        .q     (intS)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ       <= IDLE;
            pulseIdx     <= '0;
            cycleCnt     <= '0;
            mode8086Q    <= 1'b0;
            capQ         <= '0;
            INTA_n       <= 1'b1;
            busy         <= 1'b0;
            vector_valid <= 1'b0;
            proto_err    <= 1'b0;
            vector       <= '0;
            isr_addr     <= '0;
        end else begin
            stateQ       <= stateNext;
            pulseIdx     <= pulseIdxNext;
            cycleCnt     <= cycleCntNext;
            mode8086Q    <= mode8086Next;
            capQ         <= capNext;
            INTA_n       <= intaNext;
            busy         <= busyNext;
            vector_valid <= validNext;
            proto_err    <= errNext;
            vector       <= vectorNext;
            isr_addr     <= isrAddrNext;
        end
    end

    // Next-state: sequencing, counters and intermediate captures
    always_comb begin
        stateNext    = stateQ;
        pulseIdxNext = pulseIdx;
        cycleCntNext = cycleCnt;
        mode8086Next = mode8086Q;
        capNext      = capQ;

        unique case (stateQ)
            IDLE: begin
                pulseIdxNext = '0;
                cycleCntNext = '0;
                if (intS && int_enable) begin
                    stateNext    = PULSE;
                    mode8086Next = mode_8086;
                    capNext      = '0;
                end
            end
            PULSE: begin
                if (cycleCnt == PULSE_LAST) begin
                    cycleCntNext = '0;
                    if (!mode8086Q) begin
                        if (pulseIdx == 2'd0) capNext.opBad = (data_in != CALL_OPCODE);
                        if (pulseIdx == 2'd1) capNext.lo    = data_in;
                    end
                    if (pulseIdx == lastPulseIdx(mode8086Q)) stateNext = DONE;
                    else                                     stateNext = GAP;
                end else begin
                    cycleCntNext = cycleCnt + 4'd1;
                end
            end
            GAP: begin
                if (cycleCnt == GAP_LAST) begin
                    cycleCntNext = '0;
                    pulseIdxNext = pulseIdx + 2'd1;
                    stateNext    = PULSE;
                end else begin
                    cycleCntNext = cycleCnt + 4'd1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Outputs: registered versions track the next state; results commit on DONE entry
    always_comb begin
        intaNext    = (stateNext != PULSE);
        busyNext    = (stateNext != IDLE);
        validNext   = 1'b0;
        errNext     = 1'b0;
        vectorNext  = vector;
        isrAddrNext = isr_addr;

        if (stateQ == PULSE && stateNext == DONE) begin
            validNext = 1'b1;
            if (mode8086Q) begin
                vectorNext = data_in;
            end else begin
                isrAddrNext = {data_in, capQ.lo};
                errNext     = capQ.opBad;
            end
        end
    end

endmodule
